// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported handshake memory between the
// instruction-fetch port and the data-memory port of the pipeline.
// One transaction at a time, data side first; stall_o holds the pipeline
// until every access requested in the current step has completed.
// Optional feature: define MEM_ARB_IBUF_EN to add a one-entry fetch buffer
// that answers a repeated fetch of the same address without a memory access.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;

    logic              dm_done_r;
    logic              if_done_r;
    logic              dm_pend_s;
    logic              if_pend_s;
    logic              stall_s;

    logic              issue_dm_s;
    logic              issue_if_s;
    logic              dm_ack_s;
    logic              if_ack_s;
    logic              ibuf_hit_s;
    logic              ibuf_match_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_data_r;
    logic [DATA_W-1:0] dm_rdata_r;

`ifdef MEM_ARB_IBUF_EN
    logic              ibuf_valid_r;
    logic [ADDR_W-1:0] ibuf_addr_r;
    logic [DATA_W-1:0] ibuf_data_r;

    // A fetch hits when the buffer holds exactly the requested address.
    assign ibuf_match_s = ibuf_valid_r && (ibuf_addr_r == if_addr_i);
`else
    assign ibuf_match_s = 1'b0;
`endif

    // Pending work is what the current step asked for and has not yet got;
    // stall stays combinational so it also follows the inputs during reset.
    assign dm_pend_s = (dm_read_i | dm_write_i) & ~dm_done_r;
    assign if_pend_s = if_req_i & ~if_done_r;
    assign stall_s   = dm_pend_s | if_pend_s;

    assign stall_o     = stall_s;
    assign dm_ready_o  = dm_done_r;
    assign if_ready_o  = if_done_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign if_data_o   = if_data_r;
    assign dm_rdata_o  = dm_rdata_r;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and issue/ack decode; data side wins in IDLE, acks outside
    // a busy state fall through unused.
    always_comb begin
        next_state_s = state_r;
        issue_dm_s   = 1'b0;
        issue_if_s   = 1'b0;
        dm_ack_s     = 1'b0;
        if_ack_s     = 1'b0;
        ibuf_hit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (dm_pend_s) begin
                    next_state_s = DM_BUSY;
                    issue_dm_s   = 1'b1;
                end else if (if_pend_s) begin
                    if (ibuf_match_s) begin
                        next_state_s = IDLE;
                        ibuf_hit_s   = 1'b1;
                    end else begin
                        next_state_s = IF_BUSY;
                        issue_if_s   = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            DM_BUSY: begin
                if (mem_ack_i) begin
                    next_state_s = IDLE;
                    dm_ack_s     = 1'b1;
                end else begin
                    next_state_s = DM_BUSY;
                end
            end
            IF_BUSY: begin
                if (mem_ack_i) begin
                    next_state_s = IDLE;
                    if_ack_s     = 1'b1;
                end else begin
                    next_state_s = IF_BUSY;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Memory request fields: latched at issue, held stable until the ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (issue_dm_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= dm_write_i;
            mem_addr_r  <= dm_addr_i;
            mem_wdata_r <= dm_wdata_i;
        end else if (issue_if_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr_i;
            mem_wdata_r <= mem_wdata_r;
        end else if (dm_ack_s || if_ack_s) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end else begin
            mem_req_r   <= mem_req_r;
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

    // Read data capture; a write ack leaves the data-read register alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dm_rdata_r <= {DATA_W{1'b0}};
            if_data_r  <= {DATA_W{1'b0}};
        end else begin
            if (dm_ack_s && !mem_we_r) begin
                dm_rdata_r <= mem_rdata_i;
            end else begin
                dm_rdata_r <= dm_rdata_r;
            end
            if (if_ack_s) begin
                if_data_r <= mem_rdata_i;
`ifdef MEM_ARB_IBUF_EN
            end else if (ibuf_hit_s) begin
                if_data_r <= ibuf_data_r;
`endif
            end else begin
                if_data_r <= if_data_r;
            end
        end
    end

    // Done flags: set on completion (which wins), cleared when the pipeline
    // advances so a flushed access is simply dropped by the requester.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dm_done_r <= 1'b0;
            if_done_r <= 1'b0;
        end else begin
            if (dm_ack_s) begin
                dm_done_r <= 1'b1;
            end else if (!stall_s) begin
                dm_done_r <= 1'b0;
            end else begin
                dm_done_r <= dm_done_r;
            end
            if (if_ack_s || ibuf_hit_s) begin
                if_done_r <= 1'b1;
            end else if (!stall_s) begin
                if_done_r <= 1'b0;
            end else begin
                if_done_r <= if_done_r;
            end
        end
    end

`ifdef MEM_ARB_IBUF_EN
    // Fetch buffer: refilled by every fetch from memory, dropped when a data
    // write lands on the buffered address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ibuf_valid_r <= 1'b0;
            ibuf_addr_r  <= {ADDR_W{1'b0}};
            ibuf_data_r  <= {DATA_W{1'b0}};
        end else if (if_ack_s) begin
            ibuf_valid_r <= 1'b1;
            ibuf_addr_r  <= mem_addr_r;
            ibuf_data_r  <= mem_rdata_i;
        end else if (dm_ack_s && mem_we_r && (mem_addr_r == ibuf_addr_r)) begin
            ibuf_valid_r <= 1'b0;
            ibuf_addr_r  <= ibuf_addr_r;
            ibuf_data_r  <= ibuf_data_r;
        end else begin
            ibuf_valid_r <= ibuf_valid_r;
            ibuf_addr_r  <= ibuf_addr_r;
            ibuf_data_r  <= ibuf_data_r;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-ported, handshake-driven memory between the pipeline's instruction-fetch port and its data-memory port. It sits between the PC/IFID stage and the EXMEM/MEMWB stage on one side and a unified memory on the other. It issues one memory transaction at a time, with data-side priority. It drives a pipeline-wide stall until every pending access of the current cycle has completed.

## Interface
- `ADDR_W`, 32: address width (byte address, word aligned).
- `DATA_W`, 32: data width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `if_req_i` in 1: fetch request. Held with `if_addr_i` while `stall_o`=1.
- `if_addr_i` in ADDR_W: fetch address (PC).
- `if_data_o` out DATA_W: fetched instruction. Registered; valid while `if_ready_o`=1.
- `if_ready_o` out 1: fetch for the current pipeline step is complete.
- `dm_read_i` in 1: data read request (EXMEM MemRead).
- `dm_write_i` in 1: data write request (EXMEM MemWrite).
- `dm_addr_i` in ADDR_W: data address.
- `dm_wdata_i` in DATA_W: write data.
- `dm_rdata_o` out DATA_W: read data. Registered; valid while `dm_ready_o`=1.
- `dm_ready_o` out 1: data access for the current pipeline step is complete.
- `stall_o` out 1: freeze PC and all pipeline registers.
- `mem_req_o` out 1: memory request. Held until `mem_ack_i`.
- `mem_we_o` out 1: 1 = write, 0 = read.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_wdata_o` out DATA_W: memory write data.
- `mem_ack_i` in 1: transaction done. `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in DATA_W: memory read data.

## Operation
- Pending conditions:
  - `dm_pend` = (`dm_read_i` | `dm_write_i`) & ~`dm_done`.
  - `if_pend` = `if_req_i` & ~`if_done`.
- `stall_o` is combinational: `dm_pend` | `if_pend`.
- The done flags `dm_done` and `if_done` drive `dm_ready_o` and `if_ready_o`. Both flags clear on any clock edge where `stall_o`=0, i.e. when the pipeline advances.
- FSM states: IDLE, DM_BUSY, IF_BUSY.
- IDLE:
  - `dm_pend` → DM_BUSY. Latch `dm_addr_i`, `dm_wdata_i`, and `mem_we_o` = `dm_write_i`.
  - Otherwise `if_pend` → IF_BUSY. Latch `if_addr_i`, with `mem_we_o`=0.
  - Otherwise stay in IDLE.
- DM_BUSY / IF_BUSY:
  - `mem_req_o`=1 and the latched fields are stable every cycle until `mem_ack_i`.
  - On `mem_ack_i`: set the matching done flag and return to IDLE.
  - A DM read or IF access also registers `mem_rdata_i` into `dm_rdata_o` or `if_data_o`.
  - A write leaves `dm_rdata_o` unchanged.
- Data has priority because it belongs to the older instruction. A fetch waits behind it and is never preempted mid-transaction.
- Request withdrawn during BUSY (flush): the transaction completes. The done flag is set and cleared at the next non-stalled edge; the data is discarded by the requester.
- `mem_ack_i` outside a BUSY state is ignored.
- Reset (asynchronous, any state):
  - FSM → IDLE; `dm_done`=`if_done`=0.
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `if_data_o`, `dm_rdata_o` = 0.
  - `mem_req_o` drops in the same cycle.
  - `stall_o` follows the request inputs even while reset is asserted.

## Timing
- Request seen in IDLE at cycle N:
  - `mem_req_o`=1 at N+1.
  - Earliest ack at N+1.
  - Done flag and ready output at N+2.
- Single access, zero-wait ack: `stall_o` high for 2 cycles.
- Data plus fetch in the same step, zero-wait ack: `stall_o` high for 4 cycles; the fetch is issued at N+2.
- Each cycle of ack delay adds one stall cycle.
- No request: `stall_o`=0 and no memory traffic.

## Configuration
- `MEM_ARB_IBUF_EN` defined: adds a one-entry fetch buffer (valid, address, data).
  - The buffer is filled on every IF_BUSY ack.
  - In IDLE, with no `dm_pend` and `if_pend` with `if_addr_i` equal to the buffered address and the buffer valid, `if_done` is set at the next edge. No memory transaction is issued. `if_data_o` is loaded from the buffer.
  - A DM write ack to the buffered address invalidates the buffer.
  - Reset clears the valid bit.
- Not defined: every fetch goes to memory.

## Test plan
- Fetch only: `if_addr_i`=0x10, ack at first `mem_req_o` cycle with `mem_rdata_i`=0x00500093 → `if_ready_o`=1 and `if_data_o`=0x00500093 at N+2, `stall_o` high exactly 2 cycles.
- `dm_read_i` at 0x20 and fetch at 0x14 together, zero-wait ack → `mem_addr_o` is 0x20 then 0x14, `stall_o` high 4 cycles, both ready outputs high in the final cycle.
- `dm_write_i` at 0x40 with data 0xDEADBEEF, ack delayed 3 cycles → `mem_req_o`/`mem_we_o` stay high with address and data stable for 3 cycles, `dm_rdata_o` unchanged, then `stall_o` drops.
- `rst_i` low mid-DM_BUSY → `mem_req_o`=0 immediately, all registered outputs 0; after release, a pending request restarts from IDLE.
- Fetch request withdrawn during IF_BUSY → transaction still completes on ack, no second transaction, `if_ready_o` cleared after the next unstalled edge.
- With `MEM_ARB_IBUF_EN`:
  - Fetch 0x14 twice → second fetch has no `mem_req_o` and `stall_o` high 1 cycle.
  - DM write to 0x14, then fetch 0x14 → goes to memory.
  - Without the macro, the second fetch goes to memory.
